// File: rtl/serial_frame_deser_pkg.sv
// Shared types and default parameters for the serial frame deserializer.
// Imported by the sync detector and the top level.
package deser_pkg;

    typedef enum logic {
        HUNT    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    localparam int         DESER_WIDTH    = 8;
    localparam int         DESER_SYNC_LEN = 4;
    localparam logic [3:0] DESER_SYNC     = 4'b1011;
    localparam int         DESER_WORDS    = 2;

    // Counter width for a modulo-n count, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_frame_deser_if.sv
// Serial input and parallel valid/ready output bundle of the deserializer.
// The master modport is the deserializer side; the slave modport is its environment.
interface serial_frame_deser_if #(
    parameter int WIDTH = deser_pkg::DESER_WIDTH
);
    logic             din;
    logic             din_valid;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             frame_start;
    logic             in_frame;
    logic             overflow;

    modport master (
        input  din, din_valid, dout_ready,
        output dout, dout_valid, frame_start, in_frame, overflow
    );

    modport slave (
        output din, din_valid, dout_ready,
        input  dout, dout_valid, frame_start, in_frame, overflow
    );
endinterface

// File: rtl/serial_frame_deser_sync_detector.sv
// Overlapping sync-pattern detector: bit history plus comparator.
// match is combinational on the incoming bit so the FSM can react on the same edge.
module sync_detector
    import deser_pkg::*;
#(
    parameter int                  SYNC_LEN = DESER_SYNC_LEN,
    parameter logic [SYNC_LEN-1:0] SYNC     = SYNC_LEN'(DESER_SYNC)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic bit_in,
    input  logic bit_valid,
    input  logic clear,
    output logic match
);

    // The oldest history bit only ever leaves the window, so SYNC_LEN-1 stored bits suffice.
    logic [SYNC_LEN-2:0] hist_reg;
    logic [SYNC_LEN-1:0] window;

    assign window[0] = bit_in;

    generate
        for (genvar gi = 1; gi < SYNC_LEN; gi++) begin : g_window
            assign window[gi] = hist_reg[gi-1];
        end
    endgenerate

    assign match = bit_valid && (window == SYNC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_reg <= '0;
        end else if (clear) begin
            hist_reg <= '0;
        end else if (bit_valid) begin
            hist_reg <= window[SYNC_LEN-2:0];
        end
    end

endmodule

// File: rtl/serial_frame_deser.sv
// Serial frame deserializer: hunts for a sync pattern, then packs WORDS
// WIDTH-bit words MSB-first into a one-entry valid/ready holding register.
module serial_frame_deser
    import deser_pkg::*;
#(
    parameter int                  WIDTH    = DESER_WIDTH,
    parameter int                  SYNC_LEN = DESER_SYNC_LEN,
    parameter logic [SYNC_LEN-1:0] SYNC     = SYNC_LEN'(DESER_SYNC),
    parameter int                  WORDS    = DESER_WORDS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_frame_deser_if.master bus
);

    localparam int BW = cnt_width(WIDTH);
    localparam int WW = cnt_width(WORDS);
    localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);
    localparam logic [WW-1:0] WORD_LAST = WW'(WORDS - 1);

    state_t state_reg, state_next;

    logic [BW-1:0]    bit_cnt_reg;
    logic [WW-1:0]    word_cnt_reg;
    logic [WIDTH-1:0] word_reg;
    logic [WIDTH-1:0] dout_reg;
    logic             dout_valid_reg;
    logic             frame_start_reg;
    logic             in_frame_reg;
    logic             overflow_reg;

    logic             hunt_bit;
    logic             collect_bit;
    logic             word_done;
    logic             frame_done;
    logic             match;
    logic [WIDTH-1:0] word_new;

    assign word_new = {word_reg[WIDTH-2:0], bus.din};

    sync_detector #(
        .SYNC_LEN (SYNC_LEN),
        .SYNC     (SYNC)
    ) u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .bit_in    (bus.din),
        .bit_valid (hunt_bit),
        .clear     (frame_done),
        .match     (match)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= HUNT;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            HUNT:    if (match)      state_next = COLLECT;
            COLLECT: if (frame_done) state_next = HUNT;
            default:                 state_next = HUNT;
        endcase
    end

    always_comb begin
        hunt_bit    = 1'b0;
        collect_bit = 1'b0;
        word_done   = 1'b0;
        frame_done  = 1'b0;
        if (bus.din_valid) begin
            hunt_bit    = (state_reg == HUNT);
            collect_bit = (state_reg == COLLECT);
        end
        word_done  = collect_bit && (bit_cnt_reg == BIT_LAST);
        frame_done = word_done && (word_cnt_reg == WORD_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_reg  <= '0;
            word_cnt_reg <= '0;
            word_reg     <= '0;
        end else if (match) begin
            bit_cnt_reg  <= '0;
            word_cnt_reg <= '0;
        end else if (collect_bit) begin
            word_reg <= word_new;
            if (word_done) begin
                bit_cnt_reg  <= '0;
                word_cnt_reg <= word_cnt_reg + 1'b1;
            end else begin
                bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end
        end
    end

    // A consume and a load on the same edge simply replace the held word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_reg        <= '0;
            dout_valid_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
            in_frame_reg    <= 1'b0;
            overflow_reg    <= 1'b0;
        end else begin
            frame_start_reg <= match;
            in_frame_reg    <= (state_next == COLLECT);
            overflow_reg    <= 1'b0;
            if (word_done) begin
                if (!dout_valid_reg || bus.dout_ready) begin
                    dout_reg       <= word_new;
                    dout_valid_reg <= 1'b1;
                end else begin
                    overflow_reg <= 1'b1;
                end
            end else if (dout_valid_reg && bus.dout_ready) begin
                dout_valid_reg <= 1'b0;
            end
        end
    end

    assign bus.dout        = dout_reg;
    assign bus.dout_valid  = dout_valid_reg;
    assign bus.frame_start = frame_start_reg;
    assign bus.in_frame    = in_frame_reg;
    assign bus.overflow    = overflow_reg;

endmodule

// File: tb/tb_serial_frame_deser.sv
// Bench for serial_frame_deser: directed frames with literal expectations,
// then random traffic, all compared each cycle against a bit-stream model.
module tb_serial_frame_deser;
    import deser_pkg::*;

    localparam int W      = 8;
    localparam int SL     = 4;
    localparam int NW     = 2;
    localparam int SYNC_V = 11;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_frame_deser_if #(.WIDTH(W)) bus_if ();

    serial_frame_deser #(
        .WIDTH    (W),
        .SYNC_LEN (SL),
        .SYNC     (4'b1011),
        .WORDS    (NW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    int checks = 0;
    int errors = 0;

    // Model: pos = -1 while hunting, otherwise number of data bits taken this frame.
    int m_hist = 0, m_pos = -1, m_cur = 0, m_word = 0, m_dout = 0;
    bit m_dv = 0, m_fs = 0, m_ov = 0, m_if = 0, m_done = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            m_hist = 0; m_pos = -1; m_cur = 0; m_dout = 0;
            m_dv = 0; m_fs = 0; m_ov = 0; m_if = 0;
        end else begin
            m_fs = 0; m_ov = 0; m_done = 0;
            if (bus_if.din_valid) begin
                if (m_pos < 0) begin
                    m_hist = ((m_hist << 1) | int'(bus_if.din)) & ((1 << SL) - 1);
                    if (m_hist == SYNC_V) begin
                        m_pos = 0; m_cur = 0; m_fs = 1;
                    end
                end else begin
                    m_cur = ((m_cur << 1) | int'(bus_if.din)) & ((1 << W) - 1);
                    m_pos++;
                    if (m_pos % W == 0) begin
                        m_done = 1; m_word = m_cur;
                    end
                    if (m_pos == W * NW) begin
                        m_pos = -1; m_hist = 0;
                    end
                end
            end
            if (m_done) begin
                if (!m_dv || bus_if.dout_ready) begin
                    m_dout = m_word; m_dv = 1;
                end else begin
                    m_ov = 1;
                end
            end else if (m_dv && bus_if.dout_ready) begin
                m_dv = 0;
            end
            m_if = (m_pos >= 0);
        end
    end

    always @(posedge clk) begin
        #1;
        chk("cyc_dout_valid", int'(bus_if.dout_valid), int'(m_dv));
        chk("cyc_dout", int'(bus_if.dout), m_dout);
        chk("cyc_frame_start", int'(bus_if.frame_start), int'(m_fs));
        chk("cyc_in_frame", int'(bus_if.in_frame), int'(m_if));
        chk("cyc_overflow", int'(bus_if.overflow), int'(m_ov));
    end

    task automatic drive(input bit b, input bit v);
        @(negedge clk);
        bus_if.din       = b;
        bus_if.din_valid = v;
        @(posedge clk);
        #2;
    endtask

    task automatic send_bits(input int val, input int n);
        for (int i = n - 1; i >= 0; i--) drive(bit'((val >> i) & 1), 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0);
    endtask

    initial begin
        bus_if.din        = 1'b0;
        bus_if.din_valid  = 1'b0;
        bus_if.dout_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_dout", int'(bus_if.dout), 0);
        chk("rst_dout_valid", int'(bus_if.dout_valid), 0);
        chk("rst_in_frame", int'(bus_if.in_frame), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic frame, consumer always ready
        send_bits(5, 3);
        chk("t1_no_early_sync", int'(bus_if.frame_start), 0);
        drive(1'b1, 1'b1);
        chk("t1_frame_start", int'(bus_if.frame_start), 1);
        chk("t1_in_frame", int'(bus_if.in_frame), 1);
        send_bits(8'hA5, 8);
        chk("t1_dout", int'(bus_if.dout), 8'hA5);
        chk("t1_dout_valid", int'(bus_if.dout_valid), 1);
        idle(1);
        chk("t1_dout_valid_drop", int'(bus_if.dout_valid), 0);
        send_bits(8'h00, 8);
        chk("t1_frame_end", int'(bus_if.in_frame), 0);
        idle(2);

        // Backpressure: second word dropped
        bus_if.dout_ready = 1'b0;
        send_bits(4'b1011, 4);
        send_bits(8'h3C, 8);
        chk("t2_held", int'(bus_if.dout), 8'h3C);
        send_bits(8'hC3, 8);
        chk("t2_overflow", int'(bus_if.overflow), 1);
        chk("t2_in_frame_fall", int'(bus_if.in_frame), 0);
        chk("t2_dout_kept", int'(bus_if.dout), 8'h3C);
        idle(1);
        chk("t2_overflow_one_cycle", int'(bus_if.overflow), 0);
        bus_if.dout_ready = 1'b1;
        idle(2);

        // Simultaneous consume and load
        bus_if.dout_ready = 1'b0;
        send_bits(4'b1011, 4);
        send_bits(8'h3C, 8);
        send_bits(8'hC3 >> 1, 7);
        bus_if.dout_ready = 1'b1;
        drive(1'b1, 1'b1);
        bus_if.dout_ready = 1'b0;
        chk("t3_dout", int'(bus_if.dout), 8'hC3);
        chk("t3_dout_valid", int'(bus_if.dout_valid), 1);
        chk("t3_no_overflow", int'(bus_if.overflow), 0);
        bus_if.dout_ready = 1'b1;
        idle(2);

        // din_valid gaps on every other cycle
        for (int i = 3; i >= 0; i--) begin
            drive(bit'((11 >> i) & 1), 1'b1);
            drive(1'b0, 1'b0);
        end
        for (int i = 7; i > 0; i--) begin
            drive(bit'((8'hA5 >> i) & 1), 1'b1);
            drive(1'b1, 1'b0);
        end
        drive(1'b1, 1'b1);
        chk("t4_dout", int'(bus_if.dout), 8'hA5);
        chk("t4_dout_valid", int'(bus_if.dout_valid), 1);
        for (int i = 7; i >= 0; i--) begin
            drive(bit'((8'h5A >> i) & 1), 1'b1);
            drive(1'b0, 1'b0);
        end
        chk("t4_dout2", int'(bus_if.dout), 8'h5A);
        idle(2);

        // Overlapping sync and no false match after frame end
        send_bits(5'b11011 >> 1, 4);
        chk("t5_no_match_4th", int'(bus_if.frame_start), 0);
        drive(1'b1, 1'b1);
        chk("t5_match_5th", int'(bus_if.frame_start), 1);
        send_bits(8'hFF, 8);
        chk("t5_dout", int'(bus_if.dout), 8'hFF);
        send_bits(8'hFF, 8);
        for (int i = 2; i >= 0; i--) begin
            drive(bit'((5 >> i) & 1), 1'b1);
            chk("t5_no_false_match", int'(bus_if.frame_start), 0);
        end
        drive(1'b0, 1'b1);
        idle(2);

        // Reset mid-frame
        send_bits(4'b1011, 4);
        chk("t6_sync", int'(bus_if.frame_start), 1);
        send_bits(8'h5A >> 3, 5);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_dout", int'(bus_if.dout), 0);
        chk("t6_rst_in_frame", int'(bus_if.in_frame), 0);
        chk("t6_rst_dout_valid", int'(bus_if.dout_valid), 0);
        chk("t6_rst_overflow", int'(bus_if.overflow), 0);
        chk("t6_rst_frame_start", int'(bus_if.frame_start), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus_if.din_valid = 1'b0;
        rst_n = 1'b1;
        idle(1);
        send_bits(4'b1011, 4);
        send_bits(8'h5A, 8);
        chk("t6_after_dout", int'(bus_if.dout), 8'h5A);
        send_bits(8'h96, 8);
        chk("t6_after_dout2", int'(bus_if.dout), 8'h96);
        idle(2);

        // Random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            bus_if.din        = 1'($urandom_range(0, 1));
            bus_if.din_valid  = ($urandom_range(0, 3) != 0);
            bus_if.dout_ready = ($urandom_range(0, 2) != 0);
        end
        @(negedge clk);
        bus_if.din_valid  = 1'b0;
        bus_if.dout_ready = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
